tdc_shot_sequencer: RTL



---
 rtl/tdc_pkg.sv | 18 +
 rtl/tdc_seq_timer.sv | 15 +
 rtl/tdc_shot_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared state encoding, default widths and config normalisation for the TDC shot sequencer
package tdc_pkg;
  localparam int WIN_W_DEF   = 5;
  localparam int SHOT_W_DEF  = 8;
  localparam int GAP_W_DEF   = 8;
  localparam int TMO_CYC_DEF = 255;
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_START  = 6'b000010,
    S_WINDOW = 6'b000100,
    S_DRAIN  = 6'b001000,
    S_GAP    = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;
  function automatic logic [7:0] nz(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction
endpackage

// File: rtl/tdc_seq_timer.sv
// tdc_seq_timer: loadable 8-bit down-counter; done marks the last cycle of a loaded interval
module tdc_seq_timer (
  input  logic       clk5,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] val,
  output logic       done
);
  logic [7:0] cnt;
  always_ff @(posedge clk5 or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  assign done = (cnt == 8'd1);
endmodule

// File: rtl/tdc_shot_sequencer.sv
// tdc_shot_sequencer: start/window/readout/gap sequencing of TDC shots with frame and timeout flags
module tdc_shot_sequencer
  import tdc_pkg::*;
#(
  parameter int WIN_W   = WIN_W_DEF,
  parameter int SHOT_W  = SHOT_W_DEF,
  parameter int GAP_W   = GAP_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk5,
  input  logic              rst_n,
  input  logic              cfg_en,
  input  logic [WIN_W-1:0]  cfg_win,
  input  logic [SHOT_W-1:0] cfg_shots,
  input  logic [GAP_W-1:0]  cfg_gap,
  input  logic              rd_done,
  output logic              tdc_start,
  output logic              win_open,
  output logic              rd_req,
  output logic              busy,
  output logic [SHOT_W-1:0] shot_cnt,
  output logic              frame_done,
  output logic              err_tmo
);
  state_t st, nxt;
  logic [7:0] win_q, gap_q, ld_val;
  logic [SHOT_W-1:0] shots_q;
  logic ld, t_done, inc, tmo;
  tdc_seq_timer u_timer (.clk5(clk5), .rst_n(rst_n), .load(ld), .val(ld_val), .done(t_done));
  always_comb begin
    nxt = st;
    ld = 1'b0;
    ld_val = '0;
    inc = 1'b0;
    tmo = 1'b0;
    case (st)
      S_IDLE: if (cfg_en) nxt = S_START;
      S_START: begin
        nxt = S_WINDOW;
        ld = 1'b1;
        ld_val = win_q;
      end
      S_WINDOW: if (t_done) begin
        nxt = S_DRAIN;
        ld = 1'b1;
        ld_val = 8'(TMO_CYC);
      end
      S_DRAIN: if (rd_done || t_done) begin
        inc = 1'b1;
        tmo = !rd_done;
        if (shot_cnt + 1'b1 == shots_q) nxt = S_DONE;
        else if (!cfg_en) nxt = S_IDLE;
        else if (gap_q == 8'd0) nxt = S_START;
        else begin
          nxt = S_GAP;
          ld = 1'b1;
          ld_val = gap_q;
        end
      end
      S_GAP: if (t_done) nxt = cfg_en ? S_START : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
  // outputs are registered from nxt so they line up with the state they describe
  always_ff @(posedge clk5 or negedge rst_n)
    if (!rst_n) begin
      st <= S_IDLE;
      tdc_start <= 1'b0;
      win_open <= 1'b0;
      rd_req <= 1'b0;
      busy <= 1'b0;
      frame_done <= 1'b0;
      err_tmo <= 1'b0;
      shot_cnt <= '0;
      win_q <= '0;
      gap_q <= '0;
      shots_q <= '0;
    end else begin
      st <= nxt;
      tdc_start <= (nxt == S_START);
      win_open <= (nxt == S_WINDOW);
      rd_req <= (nxt == S_DRAIN);
      busy <= (nxt != S_IDLE);
      frame_done <= (nxt == S_DONE);
      if (tmo) err_tmo <= 1'b1;
      if (st == S_IDLE && cfg_en) begin
        win_q <= nz(8'(cfg_win));
        gap_q <= 8'(cfg_gap);
        shots_q <= SHOT_W'(nz(8'(cfg_shots)));
        shot_cnt <= '0;
      end else if (inc && shot_cnt != '1) shot_cnt <= shot_cnt + 1'b1;
    end
endmodule
